ahbmtx_lite_1xn: RTL

Parametrised single-master AHB-Lite interconnect that decodes one master port onto NUM_SLV slave ports. It drives the broadcast address/control/write-data bus and a one-hot select, and multiplexes read data and response back by data-phase owner. It adds an internal default slave that returns the two-cycle ERROR response for unmapped accesses, plus a saturating error counter and last-error-address capture for debug. It sits between the CPU-side master and the level-2 peripheral/memory slaves.

---
 rtl/ahbmtx_lite_1xn.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ahbmtx_lite_1xn.sv
// rtl/ahbmtx_lite_1xn.sv - single-master AHB-Lite decoder/mux with default error slave and error capture
module ahbmtx_lite_1xn #(
    parameter int                    NUM_SLV  = 3,
    parameter logic [NUM_SLV*32-1:0] SLV_BASE = {32'h4000_0000, 32'h2000_0000, 32'h0000_0000},
    parameter logic [NUM_SLV*32-1:0] SLV_MASK = {3{32'hF000_0000}},
    parameter int                    ERRCNT_W = 8
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic [31:0]             HADDRS,
    input  logic [1:0]              HTRANSS,
    input  logic                    HWRITES,
    input  logic [2:0]              HSIZES,
    input  logic [2:0]              HBURSTS,
    input  logic [3:0]              HPROTS,
    input  logic [31:0]             HWDATAS,
    input  logic                    HMASTLOCKS,
    output logic [31:0]             HRDATAS,
    output logic                    HREADYS,
    output logic                    HRESPS,
    output logic [NUM_SLV-1:0]      HSELM,
    output logic [31:0]             HADDRM,
    output logic [1:0]              HTRANSM,
    output logic                    HWRITEM,
    output logic [2:0]              HSIZEM,
    output logic [2:0]              HBURSTM,
    output logic [3:0]              HPROTM,
    output logic [31:0]             HWDATAM,
    output logic                    HMASTLOCKM,
    output logic                    HREADYMUXM,
    input  logic [NUM_SLV*32-1:0]   HRDATAM,
    input  logic [NUM_SLV-1:0]      HREADYOUTM,
    input  logic [NUM_SLV-1:0]      HRESPM,
    input  logic                    ERRCLR,
    output logic [ERRCNT_W-1:0]     ERRCNT,
    output logic [31:0]             ERRADDR
);

    typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_e;

    ds_state_e              ds_q;
    logic [NUM_SLV-1:0]     hit_sel;
    logic                   hit_any;
    logic [NUM_SLV:0]       dsel_q, dsel_d;
    logic [31:0]            daddr_q, daddr_d;
    logic [ERRCNT_W-1:0]    errcnt_q, errcnt_d;
    logic [31:0]            erraddr_q, erraddr_d;
    logic                   ds_ready, ds_resp, ds_start;
    logic [31:0]            hrdata;
    logic                   hready, hresp;

    // Lowest-index match wins when decode windows overlap.
    always_comb begin
        hit_sel = '0;
        hit_any = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (!hit_any && ((HADDRS & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32])) begin
                hit_sel[i] = 1'b1;
                hit_any    = 1'b1;
            end
        end
    end

    assign HSELM      = hit_sel;
    assign HADDRM     = HADDRS;
    assign HTRANSM    = HTRANSS;
    assign HWRITEM    = HWRITES;
    assign HSIZEM     = HSIZES;
    assign HBURSTM    = HBURSTS;
    assign HPROTM     = HPROTS;
    assign HWDATAM    = HWDATAS;
    assign HMASTLOCKM = HMASTLOCKS;
    assign HREADYMUXM = HREADYS;

    assign ds_ready = (ds_q != DS_ERR1);
    assign ds_resp  = (ds_q != DS_IDLE);

    always_comb begin
        hrdata = '0;
        hready = 1'b1;
        hresp  = 1'b0;
        if (dsel_q[NUM_SLV]) begin
            hready = ds_ready;
            hresp  = ds_resp;
        end
        for (int i = 0; i < NUM_SLV; i++) begin
            if (dsel_q[i]) begin
                hrdata = HRDATAM[i*32 +: 32];
                hready = HREADYOUTM[i];
                hresp  = HRESPM[i];
            end
        end
    end

    assign HRDATAS = hrdata;
    assign HREADYS = hready;
    assign HRESPS  = hresp;
    assign ERRCNT  = errcnt_q;
    assign ERRADDR = erraddr_q;

    assign ds_start = HREADYS & HTRANSS[1] & ~hit_any;

    always_comb begin
        dsel_d    = HREADYS ? {~hit_any, hit_sel} : dsel_q;
        daddr_d   = HREADYS ? HADDRS : daddr_q;
        errcnt_d  = errcnt_q;
        erraddr_d = erraddr_q;
        if (HREADYS && HRESPS) begin
            erraddr_d = daddr_q;
            if (errcnt_q != '1) begin
                errcnt_d = errcnt_q + ERRCNT_W'(1);
            end
        end
        if (ERRCLR) begin
            errcnt_d = '0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dsel_q    <= {1'b1, {NUM_SLV{1'b0}}};
            daddr_q   <= '0;
            errcnt_q  <= '0;
            erraddr_q <= '0;
        end else begin
            dsel_q    <= dsel_d;
            daddr_q   <= daddr_d;
            errcnt_q  <= errcnt_d;
            erraddr_q <= erraddr_d;
        end
    end

    // ERR2 already has HREADYS high, so it accepts the next address like IDLE does.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            ds_q <= DS_IDLE;
        end else begin
            case (ds_q)
                DS_IDLE: ds_q <= ds_start ? DS_ERR1 : DS_IDLE;
                DS_ERR1: ds_q <= DS_ERR2;
                DS_ERR2: ds_q <= ds_start ? DS_ERR1 : DS_IDLE;
                default: ds_q <= DS_IDLE;
            endcase
        end
    end

endmodule
